// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle Moore instruction sequencer with memory stretch, key wait and interrupt.
// Latency: 2 cycles per ALU/branch/jump/OUT/NOP, 2+MEM_WAIT for LW/SW, IN/KBD until a debounced key press.
// Backpressure: none; the sequencer itself stalls in MEM/WAIT_IN/HALT and never drops an instruction.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-low reset
//   Opcode               instruction opcode, sampled in FETCH only
//   Button               asynchronous user key (synchronised and debounced internally)
//   IrqReq               level interrupt request, honoured in FETCH and HALT
//   AluOp..Halt          datapath, branch/jump and I/O controls (Moore: state + latched opcode)
//   PCWrite              one-cycle retire pulse
//   IrqAck               one-cycle interrupt-taken pulse
//   RetireCount          wrapping count of PCWrite pulses
module control_sequencer #(
    parameter int OPCODE_W = 6,
    parameter int MEM_WAIT = 1,
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                Button,
    input  logic                IrqReq,
    output logic [2:0]          AluOp,
    output logic                RegDst,
    output logic                ALUSrc,
    output logic                MemtoReg,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                RegWrite,
    output logic                BEQ,
    output logic                BNE,
    output logic                ControlJump,
    output logic                JAL,
    output logic                In,
    output logic                Out,
    output logic                KeyboardInput,
    output logic                Halt,
    output logic                PCWrite,
    output logic                IrqAck,
    output logic [CNT_W-1:0]    RetireCount
);

    localparam int MW_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam int DB_W = $clog2(DEBOUNCE + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SUBI  = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_XORI  = 6'b101101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_OUT   = 6'b011110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_IN    = 6'b011111;
    localparam logic [5:0] OP_KBD   = 6'b000111;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_EXEC    = 3'd1,
        S_MEM     = 3'd2,
        S_WAIT_IN = 3'd3,
        S_HALT    = 3'd4,
        S_IRQ     = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [OPCODE_W-1:0]   r_opcode;
    logic [MW_W-1:0]       r_mem_cnt;
    logic [CNT_W-1:0]      r_retire;

    logic                  r_btn_s1;
    logic                  r_btn_s2;
    logic                  r_btn_lvl;
    logic                  r_btn_lvl_d;
    logic [DB_W-1:0]       r_db_cnt;

    // Full-width compare: any set bit above [5:0] makes the opcode unknown.
    function automatic logic f_is(input logic [OPCODE_W-1:0] op, input logic [5:0] code);
        f_is = (op == OPCODE_W'(code));
    endfunction

    logic w_op_rtype, w_op_addi, w_op_subi, w_op_andi, w_op_ori, w_op_slti, w_op_xori;
    logic w_op_beq, w_op_bne, w_op_j, w_op_jal, w_op_out;
    logic w_op_lw, w_op_sw, w_op_in, w_op_kbd, w_op_halt;
    logic w_op_imm;
    logic [2:0] w_imm_aluop;
    logic w_mem_last;
    logic w_db_hit;
    logic w_btn_rise;

    assign w_op_rtype = f_is(r_opcode, OP_RTYPE);
    assign w_op_addi  = f_is(r_opcode, OP_ADDI);
    assign w_op_subi  = f_is(r_opcode, OP_SUBI);
    assign w_op_andi  = f_is(r_opcode, OP_ANDI);
    assign w_op_ori   = f_is(r_opcode, OP_ORI);
    assign w_op_slti  = f_is(r_opcode, OP_SLTI);
    assign w_op_xori  = f_is(r_opcode, OP_XORI);
    assign w_op_beq   = f_is(r_opcode, OP_BEQ);
    assign w_op_bne   = f_is(r_opcode, OP_BNE);
    assign w_op_j     = f_is(r_opcode, OP_J);
    assign w_op_jal   = f_is(r_opcode, OP_JAL);
    assign w_op_out   = f_is(r_opcode, OP_OUT);
    assign w_op_lw    = f_is(r_opcode, OP_LW);
    assign w_op_sw    = f_is(r_opcode, OP_SW);
    assign w_op_in    = f_is(r_opcode, OP_IN);
    assign w_op_kbd   = f_is(r_opcode, OP_KBD);
    assign w_op_halt  = f_is(r_opcode, OP_HALT);

    assign w_op_imm = w_op_addi | w_op_subi | w_op_andi | w_op_ori | w_op_slti | w_op_xori;

    always_comb begin
        w_imm_aluop = 3'b000;
        if (w_op_subi) w_imm_aluop = 3'b001;
        if (w_op_andi) w_imm_aluop = 3'b011;
        if (w_op_ori)  w_imm_aluop = 3'b100;
        if (w_op_slti) w_imm_aluop = 3'b101;
        if (w_op_xori) w_imm_aluop = 3'b110;
    end

    assign w_mem_last = (r_mem_cnt == MW_W'(MEM_WAIT - 1));
    assign w_db_hit   = (r_db_cnt == DB_W'(DEBOUNCE - 1));
    // Registered edge of the accepted level; a level already high on
    // entry to WAIT_IN never produces this pulse.
    assign w_btn_rise = r_btn_lvl & ~r_btn_lvl_d;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and Moore outputs
    always_comb begin
        w_state_nxt   = r_state;
        AluOp         = 3'b000;
        RegDst        = 1'b0;
        ALUSrc        = 1'b0;
        MemtoReg      = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        RegWrite      = 1'b0;
        BEQ           = 1'b0;
        BNE           = 1'b0;
        ControlJump   = 1'b0;
        JAL           = 1'b0;
        In            = 1'b0;
        Out           = 1'b0;
        KeyboardInput = 1'b0;
        Halt          = 1'b0;
        PCWrite       = 1'b0;
        IrqAck        = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_state_nxt = IrqReq ? S_IRQ : S_EXEC;
            end
            S_IRQ: begin
                IrqAck      = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_HALT: begin
                Halt = 1'b1;
                if (IrqReq) begin
                    w_state_nxt = S_IRQ;
                end
            end
            S_EXEC: begin
                // Default exit: single-cycle execute retires here.
                w_state_nxt = S_FETCH;
                PCWrite     = 1'b1;
                if (w_op_rtype) begin
                    AluOp    = 3'b010;
                    RegWrite = 1'b1;
                end else if (w_op_imm) begin
                    AluOp    = w_imm_aluop;
                    ALUSrc   = 1'b1;
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end else if (w_op_beq) begin
                    AluOp = 3'b001;
                    BEQ   = 1'b1;
                end else if (w_op_bne) begin
                    AluOp = 3'b001;
                    BNE   = 1'b1;
                end else if (w_op_j) begin
                    ControlJump = 1'b1;
                end else if (w_op_jal) begin
                    ControlJump = 1'b1;
                    JAL         = 1'b1;
                    RegWrite    = 1'b1;
                end else if (w_op_out) begin
                    Out = 1'b1;
                end else if (w_op_lw || w_op_sw) begin
                    ALUSrc      = 1'b1;
                    RegDst      = 1'b1;
                    PCWrite     = 1'b0;
                    w_state_nxt = S_MEM;
                end else if (w_op_in || w_op_kbd) begin
                    PCWrite     = 1'b0;
                    w_state_nxt = S_WAIT_IN;
                end else if (w_op_halt) begin
                    PCWrite     = 1'b0;
                    w_state_nxt = S_HALT;
                end
            end
            S_MEM: begin
                ALUSrc   = 1'b1;
                RegDst   = 1'b1;
                MemRead  = w_op_lw;
                MemtoReg = w_op_lw;
                MemWrite = w_op_sw;
                if (w_mem_last) begin
                    PCWrite     = 1'b1;
                    RegWrite    = w_op_lw;
                    w_state_nxt = S_FETCH;
                end
            end
            S_WAIT_IN: begin
                In            = 1'b1;
                RegDst        = 1'b1;
                KeyboardInput = w_op_kbd;
                if (w_btn_rise) begin
                    RegWrite    = 1'b1;
                    PCWrite     = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // Opcode latch: only on a FETCH that is not diverted to IRQ.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_opcode <= '0;
        end else if (r_state == S_FETCH && !IrqReq) begin
            r_opcode <= Opcode;
        end
    end

    // Memory stretch counter: held at zero outside MEM so every entry starts fresh.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mem_cnt <= '0;
        end else if (r_state != S_MEM) begin
            r_mem_cnt <= '0;
        end else if (!w_mem_last) begin
            r_mem_cnt <= r_mem_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_retire <= '0;
        end else if (PCWrite) begin
            r_retire <= r_retire + 1'b1;
        end
    end

    assign RetireCount = r_retire;

    // Button: 2-flop synchroniser, then a run-length debouncer that runs in every state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_btn_s1    <= 1'b0;
            r_btn_s2    <= 1'b0;
            r_btn_lvl   <= 1'b0;
            r_btn_lvl_d <= 1'b0;
            r_db_cnt    <= '0;
        end else begin
            r_btn_s1    <= Button;
            r_btn_s2    <= r_btn_s1;
            r_btn_lvl_d <= r_btn_lvl;
            if (r_btn_s2 != r_btn_lvl) begin
                if (w_db_hit) begin
                    r_btn_lvl <= ~r_btn_lvl;
                    r_db_cnt  <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle, parametrised successor of the single-cycle opcode decoder: a Moore FSM that sequences each instruction over FETCH/EXEC/MEM/WAIT_IN states, stretches memory accesses to a configurable latency, waits on a debounced Button press for input instructions, and services an interrupt request between instructions. It sits between instruction memory and the datapath, driving the datapath control lines and a one-cycle PCWrite pulse per retired instruction.

## Interface
- OPCODE_W, 6: opcode width. Bits above [5:0] must be zero for a match; otherwise the opcode is unknown.
- MEM_WAIT, 1: cycles MemRead/MemWrite are held, ≥1.
- DEBOUNCE, 4: consecutive stable cycles before the synchronised Button level is accepted, ≥1.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Opcode  in  OPCODE_W  opcode of the current instruction; sampled in FETCH only.
- Button  in  1  asynchronous user key; passes a 2-flop synchroniser, then the debouncer.
- IrqReq  in  1  level interrupt request.
- AluOp  out  3  ALU operation.
- RegDst, ALUSrc, MemtoReg, MemRead, MemWrite, RegWrite  out  1 each  datapath controls.
- BEQ, BNE, ControlJump, JAL  out  1 each  branch and jump controls.
- In, Out, KeyboardInput, Halt  out  1 each  I/O and halt controls.
- PCWrite  out  1  one-cycle pulse: instruction retired, PC advances.
- IrqAck  out  1  one-cycle pulse: interrupt taken.
- RetireCount  out  CNT_W  count of PCWrite pulses; wraps at 2^CNT_W.

## Operation
- States: FETCH, EXEC, MEM, WAIT_IN, HALT, IRQ.
- Every output is a function of state and the latched opcode only. All controls are 0 in FETCH, IRQ and HALT, except Halt=1 in HALT and IrqAck=1 in IRQ.
- FETCH:
  - IrqReq=1: go to IRQ; Opcode is not latched.
  - Otherwise: latch Opcode, go to EXEC.
- IRQ: IrqAck=1 for one cycle, then FETCH. No PCWrite.
- EXEC decode (AluOp / ALUSrc / RegDst / RegWrite):
  - R-type 000000: 010 / 0 / 0 / 1.
  - ADDI 001000: 000 / 1 / 1 / 1.
  - SUBI 001001: 001 / 1 / 1 / 1.
  - ANDI 001100: 011 / 1 / 1 / 1.
  - ORI 001101: 100 / 1 / 1 / 1.
  - SLTI 001010: 101 / 1 / 1 / 1.
  - XORI 101101: 110 / 1 / 1 / 1.
  - BEQ 000100 and BNE 000101: AluOp=001, BEQ or BNE=1.
  - J 000010: ControlJump=1.
  - JAL 000011: ControlJump=1, JAL=1, RegWrite=1.
  - OUT 011110: Out=1.
  - Unknown opcode: all controls 0 (NOP).
- EXEC exits:
  - All of the above assert PCWrite in EXEC and return to FETCH.
  - LW 100011 and SW 101011: AluOp=000, ALUSrc=1, RegDst=1, no PCWrite in EXEC; go to MEM.
  - IN 011111 and KBD 000111: go to WAIT_IN.
  - HALT 111111: go to HALT.
- MEM:
  - Holds ALUSrc=1, RegDst=1, AluOp=000 for MEM_WAIT cycles.
  - LW: MemRead=1 and MemtoReg=1 throughout.
  - SW: MemWrite=1 throughout.
  - Last cycle: PCWrite=1, plus RegWrite=1 for LW. Then FETCH.
  - Internal wait counter is cleared on entry.
- WAIT_IN:
  - In=1 and RegDst=1 throughout; KeyboardInput=1 for KBD.
  - Waits for a rising edge of the debounced Button level that occurs while in WAIT_IN. A Button already high on entry must be released (debounced 0) and pressed again.
  - Edge cycle: RegWrite=1, PCWrite=1, then FETCH.
  - IrqReq is ignored in WAIT_IN.
- HALT:
  - Halt=1; stays until reset or IrqReq=1, which takes it to IRQ and then FETCH.
  - The halt instruction itself never retires.
- Debouncer: counter increments while the synchronised level differs from the accepted level, clears otherwise. When it reaches DEBOUNCE, the accepted level toggles and the counter clears. It runs in every state.
- RetireCount increments on each PCWrite and wraps from all-ones to 0.

## Timing
- Reset, async assert:
  - State = FETCH.
  - Latched opcode, RetireCount, debouncer counter, accepted level and synchroniser flops = 0.
  - All outputs 0 immediately.
- Release: first FETCH on the first rising edge after reset deasserts.
- Cycles per instruction, with PCWrite in the last cycle:
  - ALU, branch, jump, OUT, NOP: 2.
  - LW/SW: 2+MEM_WAIT.
  - IN/KBD: unbounded.
- Button to accepted level: 2 synchroniser cycles + DEBOUNCE cycles.
- Interrupt: taken only at an instruction boundary (FETCH) or from HALT; it adds 1 cycle.
- Reset asserted mid-MEM or mid-WAIT_IN aborts the instruction: no PCWrite, no RegWrite.

## Test plan
- Reset, then Opcode=001000 held: EXEC shows AluOp=000, ALUSrc=1, RegWrite=1; PCWrite pulses every 2 cycles; RetireCount=5 after 10 cycles.
- MEM_WAIT=3, LW: MemRead high for exactly 3 cycles; RegWrite and PCWrite only in the 3rd. SW: MemWrite high for 3 cycles, RegWrite never asserts.
- DEBOUNCE=4, IN with Button held high on entry: no retire. Release and re-press with a 2-cycle glitch: no retire. Stable press: RegWrite+PCWrite exactly 6 cycles after the Button rise.
- HALT: Halt=1 indefinitely with PCWrite never asserted. IrqReq=1: next cycle IrqAck=1, then FETCH.
- IrqReq pulsed during MEM: ignored until FETCH, then a 1-cycle IrqAck; the LW still retires normally.
- CNT_W=4: 16 ADDIs wrap RetireCount to 0. Reset asserted mid-MEM: all outputs 0 at once, and RetireCount=0.
